// File: rtl/gf180mcu_fd_sc_mcu9t5v0__hold_arb_pkg.sv
// Shared types and constants for the hold-keeper bus arbiter.
// Holds the FSM state encoding, counter widths and legal parameter ranges.
package gf180mcu_fd_sc_mcu9t5v0__hold_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int TA_W  = 4;
    localparam int TEN_W = 8;

    localparam int N_MIN    = 2;
    localparam int N_MAX    = 8;
    localparam int TA_MIN   = 1;
    localparam int TA_MAX   = 15;
    localparam int MAXT_MAX = 255;

    // Index width of a requester number; at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__hold_arb_if.sv
// Request/grant bundle between the bus drivers and the hold-keeper arbiter.
// Also carries the arbiter's state and priority pointer for observation.
interface gf180mcu_fd_sc_mcu9t5v0__hold_arb_if #(
    parameter int N = 4
);
    import gf180mcu_fd_sc_mcu9t5v0__hold_arb_pkg::*;

    localparam int IDX_W = idx_width(N);

    // Level handshake: a requester holds REQ[i] high for as long as it wants
    // the net; it may drive only while EN[i] is high, and GNT[i]/EN[i] fall
    // one edge after REQ[i] is sampled low or the tenure limit is reached.
    logic [N-1:0]     REQ;
    logic [N-1:0]     GNT;
    logic [N-1:0]     EN;
    logic [IDX_W-1:0] OWNER;
    logic             PARKED;
    logic             TOUT;
    state_t           dbg_state;
    logic [IDX_W-1:0] dbg_ptr;

    modport master (
        output REQ,
        input  GNT, EN, OWNER, PARKED, TOUT, dbg_state, dbg_ptr
    );

    modport slave (
        input  REQ,
        output GNT, EN, OWNER, PARKED, TOUT, dbg_state, dbg_ptr
    );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__hold_arb_rr.sv
// Combinational round-robin picker: first set request at or above the
// pointer, searching upward and wrapping modulo N.
module gf180mcu_fd_sc_mcu9t5v0__hold_arb_rr
    import gf180mcu_fd_sc_mcu9t5v0__hold_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        sel   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                sel[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__hold_arb.sv
// Round-robin owner arbiter for a tri-state net with a hold keeper: one-hot
// driver enables, a fixed parked gap between owners and a tenure limit.
module gf180mcu_fd_sc_mcu9t5v0__hold_arb
    import gf180mcu_fd_sc_mcu9t5v0__hold_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int TA   = 1,
    parameter int MAXT = 16
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu9t5v0__hold_arb_if.slave bus
);

    localparam int IDX_W = idx_width(N);

    localparam logic [TA_W-1:0]  TA_L    = TA_W'(TA);
    localparam logic [TEN_W-1:0] MAXT_L  = TEN_W'(MAXT);
    localparam logic [TEN_W-1:0] TEN_SAT = (MAXT == 0) ? TEN_W'(255) : MAXT_L;

    if (N < N_MIN || N > N_MAX || TA < TA_MIN || TA > TA_MAX ||
        MAXT < 0 || MAXT > MAXT_MAX) begin : g_param_check
        $error("hold_arb: N, TA or MAXT outside the supported range");
    end

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [N-1:0]     gnt;
    logic             parked;
    logic             tout;
    logic [TEN_W-1:0] ten_cnt;
    logic [TA_W-1:0]  ta_cnt;

    logic [N-1:0]     pick_sel;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic             owner_req;
    logic             expired;
    logic             ta_done;
    logic [IDX_W-1:0] next_ptr;

    gf180mcu_fd_sc_mcu9t5v0__hold_arb_rr #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (bus.REQ),
        .ptr   (ptr),
        .sel   (pick_sel),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_req = bus.REQ[owner];
    assign expired   = (MAXT != 0) && (ten_cnt == MAXT_L);
    assign ta_done   = (ta_cnt == TA_L);
    // Moving the pointer past the departing owner gives it lowest priority.
    assign next_ptr  = (int'(owner) == N - 1) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            gnt     <= '0;
            parked  <= 1'b1;
            tout    <= 1'b0;
            ten_cnt <= '0;
            ta_cnt  <= '0;
        end else begin
            tout <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (state == TURN && !ta_done) begin
                        ta_cnt <= ta_cnt + TA_W'(1);
                    end else if (pick_valid) begin
                        state   <= GRANT;
                        gnt     <= pick_sel;
                        owner   <= pick_idx;
                        parked  <= 1'b0;
                        ten_cnt <= TEN_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req || expired) begin
                        state   <= TURN;
                        gnt     <= '0;
                        parked  <= 1'b1;
                        ptr     <= next_ptr;
                        ta_cnt  <= TA_W'(1);
                        ten_cnt <= '0;
                        tout    <= expired && owner_req;
                    end else if (ten_cnt != TEN_SAT) begin
                        ten_cnt <= ten_cnt + TEN_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= '0;
                    parked <= 1'b1;
                end
            endcase
        end
    end

    assign bus.GNT       = gnt;
    assign bus.EN        = gnt;
    assign bus.OWNER     = owner;
    assign bus.PARKED    = parked;
    assign bus.TOUT      = tout;
    assign bus.dbg_state = state;
    assign bus.dbg_ptr   = ptr;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__hold_arb.sv
// Directed bench for the hold-keeper arbiter: a vector table on one instance
// plus hand sequences for rotation, tenure expiry and a long turnaround.
module tb_gf180mcu_fd_sc_mcu9t5v0__hold_arb;
    import gf180mcu_fd_sc_mcu9t5v0__hold_arb_pkg::*;

    logic CLK = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__hold_arb_if #(.N(4)) bus_a ();
    gf180mcu_fd_sc_mcu9t5v0__hold_arb_if #(.N(4)) bus_b ();
    gf180mcu_fd_sc_mcu9t5v0__hold_arb_if #(.N(4)) bus_c ();

    gf180mcu_fd_sc_mcu9t5v0__hold_arb #(.N(4), .TA(1), .MAXT(0)) dut_a (.CLK(CLK), .RST(rst_a), .bus(bus_a));
    gf180mcu_fd_sc_mcu9t5v0__hold_arb #(.N(4), .TA(1), .MAXT(5)) dut_b (.CLK(CLK), .RST(rst_b), .bus(bus_b));
    gf180mcu_fd_sc_mcu9t5v0__hold_arb #(.N(4), .TA(3), .MAXT(0)) dut_c (.CLK(CLK), .RST(rst_c), .bus(bus_c));

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [1:0] ptr;
        logic       parked;
        logic       tout;
        state_t     st;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Invariant monitor: onehot0 enables, EN==GNT, PARKED==~|EN and the gap.
    logic [3:0] prev_en [3] = '{4'd0, 4'd0, 4'd0};
    int         zrun    [3] = '{0, 0, 0};
    bit         had     [3] = '{1'b0, 1'b0, 1'b0};
    logic       rst_seen[3] = '{1'b1, 1'b1, 1'b1};

    always @(posedge CLK) begin
        rst_seen[0] <= rst_a;
        rst_seen[1] <= rst_b;
        rst_seen[2] <= rst_c;
    end

    task automatic inv_step(input int k, input int ta, input logic [3:0] en,
                            input logic [3:0] gnt, input logic parked);
        check($sformatf("inv%0d_onehot0", k), 32'($onehot0(en)), 32'd1);
        check($sformatf("inv%0d_en_eq_gnt", k), 32'(en), 32'(gnt));
        check($sformatf("inv%0d_parked", k), 32'(parked), 32'(~|en));
        if (rst_seen[k]) begin
            check($sformatf("inv%0d_rst_en", k), 32'(en), 32'd0);
            had[k]  = 1'b0;
            zrun[k] = 0;
        end else if (en == 4'd0) begin
            zrun[k]++;
        end else begin
            if (prev_en[k] == 4'd0 && had[k])
                check($sformatf("inv%0d_gap_ok", k), 32'(zrun[k] >= ta), 32'd1);
            if (prev_en[k] != 4'd0)
                check($sformatf("inv%0d_no_switch", k), 32'(en), 32'(prev_en[k]));
            had[k]  = 1'b1;
            zrun[k] = 0;
        end
        prev_en[k] = en;
    endtask

    always @(negedge CLK) begin
        inv_step(0, 1, bus_a.EN, bus_a.GNT, bus_a.PARKED);
        inv_step(1, 1, bus_b.EN, bus_b.GNT, bus_b.PARKED);
        inv_step(2, 3, bus_c.EN, bus_c.GNT, bus_c.PARKED);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.REQ = 4'd0; bus_b.REQ = 4'd0; bus_c.REQ = 4'd0;

        //             rst   req      gnt      own   ptr   park  tout  state
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b0, GRANT};
        vecs[3]  = '{1'b0, 4'b1110, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0, TURN};
        vecs[4]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 2'd1, 1'b0, 1'b0, GRANT};
        vecs[5]  = '{1'b0, 4'b1100, 4'b0000, 2'd1, 2'd2, 1'b1, 1'b0, TURN};
        vecs[6]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 2'd2, 1'b0, 1'b0, GRANT};
        vecs[7]  = '{1'b0, 4'b0001, 4'b0000, 2'd3, 2'd0, 1'b1, 1'b0, TURN};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd3, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 2'd0, 1'b0, 1'b0, GRANT};
        vecs[10] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 2'd0, 1'b0, 1'b0, GRANT};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 2'd3, 1'b1, 1'b0, TURN};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 2'd3, 1'b1, 1'b0, IDLE};
        vecs[13] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 2'd3, 1'b0, 1'b0, GRANT};
        vecs[14] = '{1'b1, 4'b0011, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[15] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 2'd0, 1'b0, 1'b0, GRANT};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 2'd2, 1'b1, 1'b0, TURN};
        vecs[17] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 2'd2, 1'b1, 1'b0, IDLE};
        vecs[18] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 2'd2, 1'b0, 1'b0, GRANT};
        vecs[19] = '{1'b1, 4'b0010, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[20] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[21] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 2'd0, 1'b0, 1'b0, GRANT};
        vecs[22] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 2'd0, 1'b1, 1'b0, TURN};
        vecs[23] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 2'd0, 1'b1, 1'b0, IDLE};
        vecs[24] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 2'd0, 1'b0, 1'b0, GRANT};
        vecs[25] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0, TURN};
        vecs[26] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 2'd1, 1'b1, 1'b0, IDLE};

        for (int i = 0; i < 27; i++) begin
            rst_a     = vecs[i].rst;
            bus_a.REQ = vecs[i].req;
            @(negedge CLK);
            check($sformatf("vec%0d_gnt", i),    32'(bus_a.GNT),       32'(vecs[i].gnt));
            check($sformatf("vec%0d_owner", i),  32'(bus_a.OWNER),     32'(vecs[i].owner));
            check($sformatf("vec%0d_ptr", i),    32'(bus_a.dbg_ptr),   32'(vecs[i].ptr));
            check($sformatf("vec%0d_parked", i), 32'(bus_a.PARKED),    32'(vecs[i].parked));
            check($sformatf("vec%0d_tout", i),   32'(bus_a.TOUT),      32'(vecs[i].tout));
            check($sformatf("vec%0d_state", i),  32'(bus_a.dbg_state), 32'(vecs[i].st));
        end

        // Rotation: all request, each owner drops after 3 grant cycles.
        rst_a = 1'b1; bus_a.REQ = 4'd0;
        @(negedge CLK);
        rst_a = 1'b0; bus_a.REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge CLK);
            check($sformatf("rot%0d_gnt_c1", g), 32'(bus_a.GNT), 32'(4'b0001 << (g % 4)));
            check($sformatf("rot%0d_owner", g),  32'(bus_a.OWNER), 32'(g % 4));
            for (int c = 2; c <= 3; c++) begin
                @(negedge CLK);
                check($sformatf("rot%0d_gnt_c%0d", g, c), 32'(bus_a.GNT), 32'(4'b0001 << (g % 4)));
            end
            bus_a.REQ[g % 4] = 1'b0;
            @(negedge CLK);
            check($sformatf("rot%0d_park_gnt", g), 32'(bus_a.GNT), 32'd0);
            check($sformatf("rot%0d_parked", g),   32'(bus_a.PARKED), 32'd1);
            bus_a.REQ = 4'b1111;
        end
        bus_a.REQ = 4'd0;

        // Tenure expiry with a sole requester, three rounds.
        @(negedge CLK);
        rst_b = 1'b0; bus_b.REQ = 4'b0100;
        for (int r = 0; r < 3; r++) begin
            for (int c = 1; c <= 5; c++) begin
                @(negedge CLK);
                check($sformatf("exp%0d_gnt_c%0d", r, c),  32'(bus_b.GNT),  32'(4'b0100));
                check($sformatf("exp%0d_tout_c%0d", r, c), 32'(bus_b.TOUT), 32'd0);
            end
            @(negedge CLK);
            check($sformatf("exp%0d_rel_gnt", r), 32'(bus_b.GNT),     32'd0);
            check($sformatf("exp%0d_tout", r),    32'(bus_b.TOUT),    32'd1);
            check($sformatf("exp%0d_parked", r),  32'(bus_b.PARKED),  32'd1);
            check($sformatf("exp%0d_ptr", r),     32'(bus_b.dbg_ptr), 32'd3);
        end
        bus_b.REQ = 4'd0;
        @(negedge CLK);
        check("exp_end_gnt",   32'(bus_b.GNT),       32'd0);
        check("exp_end_tout",  32'(bus_b.TOUT),      32'd0);
        check("exp_end_state", 32'(bus_b.dbg_state), 32'(IDLE));

        // Three-cycle turnaround, no preemption, then a one-cycle request.
        rst_c = 1'b0; bus_c.REQ = 4'b0001;
        @(negedge CLK);
        check("ta_first_gnt", 32'(bus_c.GNT), 32'(4'b0001));
        bus_c.REQ = 4'b0011;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check($sformatf("ta_hold%0d", c), 32'(bus_c.GNT), 32'(4'b0001));
        end
        bus_c.REQ = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check($sformatf("ta_gap%0d_en", c),     32'(bus_c.EN),     32'd0);
            check($sformatf("ta_gap%0d_parked", c), 32'(bus_c.PARKED), 32'd1);
        end
        @(negedge CLK);
        check("ta_new_en",    32'(bus_c.EN),    32'(4'b0010));
        check("ta_new_owner", 32'(bus_c.OWNER), 32'd1);

        bus_c.REQ = 4'd0;
        @(negedge CLK);
        check("ta_rel_en", 32'(bus_c.EN), 32'd0);
        repeat (3) @(negedge CLK);
        check("ta_idle_state", 32'(bus_c.dbg_state), 32'(IDLE));

        bus_c.REQ = 4'b1000;
        @(negedge CLK);
        check("pulse_gnt", 32'(bus_c.GNT), 32'(4'b1000));
        bus_c.REQ = 4'd0;
        @(negedge CLK);
        check("pulse_rel_gnt", 32'(bus_c.GNT), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check($sformatf("pulse_turn%0d", c), 32'(bus_c.dbg_state), 32'(TURN));
        end
        @(negedge CLK);
        check("pulse_idle", 32'(bus_c.dbg_state), 32'(IDLE));
        check("pulse_ptr",  32'(bus_c.dbg_ptr),   32'd0);
        bus_c.REQ = 4'b1001;
        @(negedge CLK);
        check("pulse_favor0", 32'(bus_c.GNT), 32'(4'b0001));
        bus_c.REQ = 4'd0;
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
